// File: rtl/piso_sched_pkg.sv
// Shared types and width helpers for the round-robin PISO scheduler.
package piso_sched_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  function automatic int clog2(input int v);
    int r = 0;
    int x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int num_beats(input int din, input int dout);
    return din / dout;
  endfunction

  // A one-requester index still needs a bit to carry.
  function automatic int id_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/piso_norm_sched_if.sv
// Requester/beat bus for piso_norm_sched; OUT_LAST exists only with PISO_SCHED_LAST_EN.
interface piso_norm_sched_if #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 16
);
  import piso_sched_pkg::*;
  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]               REQ_VALID;
  logic [NUM_REQ*DATA_IN_WIDTH-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]               REQ_READY;
  logic [DATA_OUT_WIDTH-1:0]        DATA_OUT;
  logic                             OUT_VALID;
  logic [ID_W-1:0]                  OUT_ID;
  logic                             BUSY;
`ifdef PISO_SCHED_LAST_EN
  logic                             OUT_LAST;
`endif

  modport master (
    output REQ_VALID, REQ_DATA,
    input  REQ_READY, DATA_OUT, OUT_VALID, OUT_ID, BUSY
`ifdef PISO_SCHED_LAST_EN
    , input OUT_LAST
`endif
  );

  modport slave (
    input  REQ_VALID, REQ_DATA,
    output REQ_READY, DATA_OUT, OUT_VALID, OUT_ID, BUSY
`ifdef PISO_SCHED_LAST_EN
    , output OUT_LAST
`endif
  );

endinterface

// File: rtl/piso_sched_shift.sv
// Load/shift stage: captures one wide word and emits it LSB slice first, one slice per cycle.
module piso_sched_shift
  import piso_sched_pkg::*;
#(
  parameter int DIN  = 64,
  parameter int DOUT = 16,
  parameter int IDW  = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            i_load,
  input  logic [DIN-1:0]  i_word,
  input  logic [IDW-1:0]  i_id,
  output logic [DOUT-1:0] o_beat,
  output logic [IDW-1:0]  o_id,
  output logic            o_vld,
  output logic            o_last
);
  localparam int NB = num_beats(DIN, DOUT);
  localparam int CW = clog2(NB);

  logic [DIN-1:0] r_sr;
  logic [IDW-1:0] r_id;
  logic [CW-1:0]  r_cnt;
  logic           r_vld;
  logic           w_last;

  assign w_last = r_vld && (r_cnt == CW'(NB - 1));

  // A load on the final beat wins, giving back-to-back words with no bubble.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sr  <= '0;
      r_id  <= '0;
      r_cnt <= '0;
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_sr  <= i_word;
      r_id  <= i_id;
      r_cnt <= '0;
      r_vld <= 1'b1;
    end else if (r_vld) begin
      r_sr <= r_sr >> DOUT;
      if (w_last) begin
        r_vld <= 1'b0;
        r_cnt <= '0;
        r_id  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_beat = r_vld ? r_sr[DOUT-1:0] : '0;
  assign o_id   = r_vld ? r_id : '0;
  assign o_vld  = r_vld;
  assign o_last = w_last;

endmodule

// File: rtl/piso_norm_sched.sv
// Round-robin scheduler feeding one shared wide-to-narrow serializer.
// Optional OUT_LAST beat marker is enabled by defining PISO_SCHED_LAST_EN.
module piso_norm_sched
  import piso_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  piso_norm_sched_if.slave bus
);
  localparam int ID_W = id_w(NUM_REQ);

  state_t                   r_state, w_state_nxt;
  logic [ID_W-1:0]          r_ptr, w_ptr_nxt, w_gidx;
  logic [NUM_REQ-1:0]       w_grant;
  logic [DATA_IN_WIDTH-1:0] w_word;
  logic                     w_window, w_load, w_last, w_vld;
  int                       w_idx;

  // Window opens when empty or on the final beat; reset closes it outright.
  assign w_window = !RESET && ((r_state == IDLE) || w_last);

  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (w_window && (w_grant == '0) && bus.REQ_VALID[w_idx]) begin
        w_grant[w_idx] = 1'b1;
        w_gidx         = ID_W'(w_idx);
      end
    end
  end

  assign w_load = |w_grant;

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_grant[i]) w_word = bus.REQ_DATA[i*DATA_IN_WIDTH +: DATA_IN_WIDTH];
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_load)
      w_ptr_nxt = (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_nxt = SHIFT;
      SHIFT:   if (w_last) w_state_nxt = w_load ? SHIFT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  piso_sched_shift #(
    .DIN  (DATA_IN_WIDTH),
    .DOUT (DATA_OUT_WIDTH),
    .IDW  (ID_W)
  ) u_shift (
    .CLK    (CLK),
    .RESET  (RESET),
    .i_load (w_load),
    .i_word (w_word),
    .i_id   (w_gidx),
    .o_beat (bus.DATA_OUT),
    .o_id   (bus.OUT_ID),
    .o_vld  (w_vld),
    .o_last (w_last)
  );

  assign bus.REQ_READY = w_grant;
  assign bus.OUT_VALID = w_vld;
  assign bus.BUSY      = (r_state == SHIFT);
`ifdef PISO_SCHED_LAST_EN
  assign bus.OUT_LAST  = w_last;
`endif

endmodule

// File: doc/piso_norm_sched.md
# piso_norm_sched

Round-robin scheduler that shares one wide-to-narrow serializer among several requesters, such as PE output lanes feeding a normalization stream. It accepts one DATA_IN_WIDTH word per handshake from the selected requester and emits it as NUM_BEATS consecutive DATA_OUT_WIDTH beats, least-significant slice first. Each beat is tagged with the source index. The block sits between the PE output collectors and the narrow normalization datapath and contains its own shift stage.

## Interface
- NUM_REQ, 4: requester count; must be at least 2.
- DATA_IN_WIDTH, 64: word width per requester.
- DATA_OUT_WIDTH, 16: beat width; DATA_IN_WIDTH must be an integer multiple of it.
- Derived constants:
  - NUM_BEATS = DATA_IN_WIDTH/DATA_OUT_WIDTH; must be at least 2.
  - ID_W = max(1, clog2(NUM_REQ)).
- CLK  in  1  clock.
- RESET  in  1  reset: RESET, synchronous, active-high; clock CLK.
- REQ_VALID  in  NUM_REQ  per-requester word valid.
- REQ_DATA  in  NUM_REQ*DATA_IN_WIDTH  packed words; requester i occupies bits [i*DATA_IN_WIDTH +: DATA_IN_WIDTH].
- REQ_READY  out  NUM_REQ  one-hot grant; a transfer happens when REQ_VALID[i] and REQ_READY[i] are both high.
- DATA_OUT  out  DATA_OUT_WIDTH  current beat; 0 when OUT_VALID is low.
- OUT_VALID  out  1  beat valid.
- OUT_ID  out  ID_W  source requester of the current beat; 0 when OUT_VALID is low.
- BUSY  out  1  shift stage holds an undelivered word.
- OUT_LAST  out  1  final beat of a word. Present only with PISO_SCHED_LAST_EN.

## Operation
- States:
  - IDLE: shift stage empty.
  - SHIFT: beats in flight; beat counter runs 0..NUM_BEATS-1.
- Grant window:
  - Open in IDLE.
  - Open in SHIFT on the cycle the counter equals NUM_BEATS-1, i.e. the last beat.
  - Closed at all other times; REQ_READY is all-zero.
- Arbitration (within an open window):
  - Search starts at rr_ptr and wraps modulo NUM_REQ.
  - The first index with REQ_VALID set is granted.
  - REQ_READY is combinational from REQ_VALID and registered state.
  - On a grant, rr_ptr becomes (granted+1) mod NUM_REQ. Without a grant, rr_ptr holds.
- Load: on a grant, the granted REQ_DATA word and its index are captured into the shift stage. The state goes to SHIFT with the counter at 0.
- Shift:
  - Each SHIFT cycle presents slice [cnt*DATA_OUT_WIDTH +: DATA_OUT_WIDTH] on DATA_OUT, then increments cnt.
  - After the last beat: a grant in that same cycle reloads the stage. Otherwise the state returns to IDLE.
- Requester obligations: hold REQ_VALID and REQ_DATA stable until the handshake. The block never drops or duplicates a word.
- No output backpressure. Downstream must accept one beat per cycle while OUT_VALID is high.
- BUSY equals state==SHIFT.

## Timing
- Reset values:
  - Outputs: REQ_READY=0, DATA_OUT=0, OUT_VALID=0, OUT_ID=0, BUSY=0, OUT_LAST=0.
  - Internal: state=IDLE, rr_ptr=0, cnt=0.
- While RESET is high, REQ_READY is forced to 0.
- Latency: a handshake in cycle t produces beats in cycles t+1..t+NUM_BEATS.
- Throughput: back-to-back grants on the last beat give continuous OUT_VALID with no bubble.
- Reset mid-word: the partial word is discarded. All outputs are 0 from the cycle after RESET is sampled.
- Simultaneous requests: exactly one is granted per window. The losers keep REQ_VALID high and are served in round-robin order.
- A REQ_VALID that drops without a handshake is ignored. Its index is not granted, and rr_ptr does not advance.

## Configuration
- PISO_SCHED_LAST_EN defined:
  - OUT_LAST port exists.
  - OUT_LAST is high exactly when OUT_VALID is high and cnt==NUM_BEATS-1.
- PISO_SCHED_LAST_EN undefined: no OUT_LAST port or logic; all other behaviour is identical.

## Structure
- Shared package/header piso_sched_pkg holds:
  - the state encodings (IDLE, SHIFT);
  - the NUM_BEATS and ID_W derivation;
  - the clog2 function.
- One sub-module, piso_sched_shift: load/shift register plus beat counter. It has a load strobe, word in, index in, beat out, valid out and a last-beat flag.
- Arbitration, rr_ptr and the grant window live in the top.

## Test plan
Defaults throughout: NUM_REQ=4, 64-bit words, 16-bit beats.
- Single word: REQ_VALID=0001 with word 0x4444_3333_2222_1111 at cycle 0.
  - REQ_READY=0001 at cycle 0.
  - DATA_OUT = 0x1111, 0x2222, 0x3333, 0x4444 in cycles 1-4; OUT_ID=0.
  - OUT_LAST at cycle 4; BUSY low at cycle 5.
- Saturation: REQ_VALID=1111 held.
  - Grants to indices 0, 1, 2, 3, 0 at cycles 0, 4, 8, 12, 16.
  - OUT_VALID continuously high from cycle 1; OUT_ID changes every 4 cycles.
- Fairness: requester 2 granted first, then REQ_VALID=1010 arrives during its shift.
  - Requester 3 is granted on the last beat.
  - Requester 1 is granted 4 cycles later.
- Idle gap: a word completes at cycle 4 and the next request arrives at cycle 7.
  - OUT_VALID=0 and BUSY=0 in cycles 5-7.
  - Grant at cycle 7; first beat at cycle 8.
- Reset mid-word: RESET high at cycle 2 of a word while requester 1 holds valid.
  - All outputs 0 from cycle 3.
  - After RESET deasserts, requester 1 is granted from rr_ptr=0 and its full word is emitted.
- Macro sweep: build with and without PISO_SCHED_LAST_EN.
  - Identical DATA_OUT, OUT_ID and REQ_READY traces in both builds.
  - OUT_LAST present only when the macro is defined.
